pmux_rr_arb: RTL

Round-robin arbiter that shares one 8-way, 16-bit priority-mux datapath among eight requesters. Each cycle it picks at most one pending requester, generates the one-hot select for the pmux, and captures the selected data word into a single-entry output register with a valid/ready handshake. It sits in front of the pmux datapath and is its only sequencer.

---
 rtl/pmux_rr_arb.sv | 97 +++++++++
 1 files changed

// File: rtl/pmux_rr_arb.sv
// Round-robin arbiter sequencing a shared N-way priority-mux datapath into a
// single-entry valid/ready output register.
`timescale 1ns/1ps
module pmux_rr_arb #(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 16,
    parameter int unsigned IW = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic [N*W-1:0]  data_i,
    output logic [N-1:0]    gnt_o,
    output logic [W-1:0]    q_o,
    output logic [IW-1:0]   q_src_o,
    output logic            q_valid_o,
    input  logic            q_ready_i
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  q_data_q, q_data_d;
    logic [IW-1:0] q_src_q, q_src_d;
    logic          q_valid_q, q_valid_d;

    logic          load_ok;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic [W-1:0]  pmux_data;

    // Search starts one past the last winner; IW-bit addition wraps modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ptr_q + IW'(i);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign load_ok = !q_valid_q || q_ready_i;

    always_comb begin
        gnt_o = '0;
        if (rst_ni && load_ok && win_found) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // Priority mux, lowest index wins; the one-hot select never exercises it.
    always_comb begin
        pmux_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt_o[N-1-k]) begin
                pmux_data = data_i[(N-1-k)*W +: W];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        q_data_d  = q_data_q;
        q_src_d   = q_src_q;
        q_valid_d = q_valid_q;
        if (|gnt_o) begin
            ptr_d     = win_idx;
            q_data_d  = pmux_data;
            q_src_d   = win_idx;
            q_valid_d = 1'b1;
        end else if (q_ready_i) begin
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= IW'(N-1);
            q_data_q  <= '0;
            q_src_q   <= '0;
            q_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            q_data_q  <= q_data_d;
            q_src_q   <= q_src_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q_o       = q_data_q;
    assign q_src_o   = q_src_q;
    assign q_valid_o = q_valid_q;

endmodule
